// File: rtl/fifo_status.sv
// Single-clock FIFO with fill level, threshold flags, sticky error flags, flush,
// and either a registered read port or a first-word-fall-through read port.
module fifo_status #(
  parameter int nrOfEntries      = 16,
  parameter int bitWidth         = 32,
  parameter int almostFullLevel  = 12,
  parameter int almostEmptyLevel = 4,
  parameter int fwftMode         = 0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               push,
  input  logic                               pop,
  input  logic [bitWidth-1:0]                pushData,
  output logic [bitWidth-1:0]                popData,
  output logic                               full,
  output logic                               empty,
  output logic                               almostFull,
  output logic                               almostEmpty,
  output logic [$clog2(nrOfEntries+1)-1:0]   fillLevel,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int cntW = $clog2(nrOfEntries + 1);
  localparam int ptrW = $clog2(nrOfEntries);

  logic [bitWidth-1:0] mem [nrOfEntries];
  logic [ptrW-1:0]     readPtr;
  logic [ptrW-1:0]     writePtr;
  logic                pushOk;
  logic                popOk;

  // Pointers wrap explicitly so depths that are not a power of two work.
  function automatic logic [ptrW-1:0] nextPtr(input logic [ptrW-1:0] p);
    return (p == ptrW'(nrOfEntries - 1)) ? '0 : p + ptrW'(1);
  endfunction

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  always_comb begin
    popOk  = pop && !empty;
    pushOk = push && (!full || popOk);
  end

  assign full        = (fillLevel == cntW'(nrOfEntries));
  assign empty       = (fillLevel == '0);
  assign almostFull  = (fillLevel >= cntW'(almostFullLevel));
  assign almostEmpty = (fillLevel <= cntW'(almostEmptyLevel));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readPtr   <= '0;
      writePtr  <= '0;
      fillLevel <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      readPtr   <= '0;
      writePtr  <= '0;
      fillLevel <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pushOk) writePtr <= nextPtr(writePtr);
      if (popOk)  readPtr  <= nextPtr(readPtr);
      case ({pushOk, popOk})
        2'b10:   fillLevel <= fillLevel + cntW'(1);
        2'b01:   fillLevel <= fillLevel - cntW'(1);
        default: fillLevel <= fillLevel;
      endcase
      if (push && !pushOk) overflow  <= 1'b1;
      if (pop && !popOk)   underflow <= 1'b1;
    end
  end

  // Storage has no reset; stale words are unreachable once pointers are zeroed.
  always_ff @(posedge clock) begin
    if (reset && !clear && pushOk) mem[writePtr] <= pushData;
  end

  generate
    if (fwftMode != 0) begin : gFwft
      assign popData = mem[readPtr];
    end else begin : gReg
      logic [bitWidth-1:0] popReg;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)     popReg <= '0;
        else if (clear) popReg <= '0;
        else if (popOk) popReg <= mem[readPtr];
      end
      assign popData = popReg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_status.sv
// Bench for fifo_status: three configurations (depth 16 registered, depth 5
// registered, depth 16 FWFT) checked against a queue-based reference model.
module tb_fifo_status;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clr [3];
  logic        psh [3];
  logic        pp  [3];
  logic [31:0] din [3];
  logic [31:0] dout [3];
  logic        dFull [3];
  logic        dEmpty [3];
  logic        dAf [3];
  logic        dAe [3];
  logic        dOvf [3];
  logic        dUnf [3];
  logic [4:0]  flA;
  logic [2:0]  flB;
  logic [4:0]  flC;

  int testCount = 0;
  int failCount = 0;

  int depth [3] = '{16, 5, 16};
  int afLvl [3] = '{12, 4, 12};
  int aeLvl [3] = '{4, 1, 4};
  bit fwft  [3] = '{1'b0, 1'b0, 1'b1};

  logic [31:0] q [3][$];
  bit          ovf [3];
  bit          unf [3];
  logic [31:0] pd [3];

  always #5 clock = ~clock;

  fifo_status #(.nrOfEntries(16), .bitWidth(32), .almostFullLevel(12), .almostEmptyLevel(4), .fwftMode(0)) dutA (
    .clock(clock), .reset(reset), .clear(clr[0]), .push(psh[0]), .pop(pp[0]), .pushData(din[0]),
    .popData(dout[0]), .full(dFull[0]), .empty(dEmpty[0]), .almostFull(dAf[0]), .almostEmpty(dAe[0]),
    .fillLevel(flA), .overflow(dOvf[0]), .underflow(dUnf[0]));

  fifo_status #(.nrOfEntries(5), .bitWidth(32), .almostFullLevel(4), .almostEmptyLevel(1), .fwftMode(0)) dutB (
    .clock(clock), .reset(reset), .clear(clr[1]), .push(psh[1]), .pop(pp[1]), .pushData(din[1]),
    .popData(dout[1]), .full(dFull[1]), .empty(dEmpty[1]), .almostFull(dAf[1]), .almostEmpty(dAe[1]),
    .fillLevel(flB), .overflow(dOvf[1]), .underflow(dUnf[1]));

  fifo_status #(.nrOfEntries(16), .bitWidth(32), .almostFullLevel(12), .almostEmptyLevel(4), .fwftMode(1)) dutC (
    .clock(clock), .reset(reset), .clear(clr[2]), .push(psh[2]), .pop(pp[2]), .pushData(din[2]),
    .popData(dout[2]), .full(dFull[2]), .empty(dEmpty[2]), .almostFull(dAf[2]), .almostEmpty(dAe[2]),
    .fillLevel(flC), .overflow(dOvf[2]), .underflow(dUnf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      ovf[k] = 1'b0;
      unf[k] = 1'b0;
      pd[k]  = '0;
    end
  endtask

  // Queue semantics: pop frees a slot before the push is judged.
  task automatic modelStep(input int k, input bit c, input bit pu, input bit po, input logic [31:0] d);
    bit popOk;
    bit pushOk;
    if (c) begin
      q[k].delete();
      ovf[k] = 1'b0;
      unf[k] = 1'b0;
      pd[k]  = '0;
      return;
    end
    popOk  = po && (q[k].size() > 0);
    pushOk = pu && ((q[k].size() < depth[k]) || popOk);
    if (po && !popOk) unf[k] = 1'b1;
    if (pu && !pushOk) ovf[k] = 1'b1;
    if (popOk) pd[k] = q[k].pop_front();
    if (pushOk) q[k].push_back(d);
  endtask

  task automatic checkOutput(input int k, input string tag);
    int n;
    logic [4:0] fl;
    n = q[k].size();
    case (k)
      0:       fl = flA;
      1:       fl = {2'b00, flB};
      default: fl = flC;
    endcase
    chk({tag, ".fillLevel"}, 32'(fl), 32'(n));
    chk({tag, ".full"}, 32'(dFull[k]), 32'(n == depth[k]));
    chk({tag, ".empty"}, 32'(dEmpty[k]), 32'(n == 0));
    chk({tag, ".almostFull"}, 32'(dAf[k]), 32'(n >= afLvl[k]));
    chk({tag, ".almostEmpty"}, 32'(dAe[k]), 32'(n <= aeLvl[k]));
    chk({tag, ".overflow"}, 32'(dOvf[k]), 32'(ovf[k]));
    chk({tag, ".underflow"}, 32'(dUnf[k]), 32'(unf[k]));
    if (!fwft[k]) chk({tag, ".popData"}, dout[k], pd[k]);
    else if (n > 0) chk({tag, ".popDataHead"}, dout[k], q[k][0]);
  endtask

  // Drives one instance for one cycle, leaves the others idle, checks at the falling edge.
  task automatic applyStimulus(input int k, input bit c, input bit pu, input bit po,
                               input logic [31:0] d, input string tag);
    for (int i = 0; i < 3; i++) begin
      clr[i] = 1'b0;
      psh[i] = 1'b0;
      pp[i]  = 1'b0;
    end
    clr[k] = c;
    psh[k] = pu;
    pp[k]  = po;
    din[k] = d;
    @(posedge clock);
    modelStep(k, c, pu, po, d);
    @(negedge clock);
    clr[k] = 1'b0;
    psh[k] = 1'b0;
    pp[k]  = 1'b0;
    checkOutput(k, tag);
  endtask

  task automatic randomRun(input int k, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++)
      applyStimulus(k, ($urandom_range(39) == 0), ($urandom_range(9) < 6),
                    ($urandom_range(9) < 5), $urandom, tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      clr[i] = 1'b0;
      psh[i] = 1'b0;
      pp[i]  = 1'b0;
      din[i] = '0;
    end

    #1 reset = 1'b0;
    #2 modelReset();
    for (int k = 0; k < 3; k++) checkOutput(k, "reset");
    @(negedge clock);
    reset = 1'b1;

    for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 1, 0, 32'(i), "fill");
    for (int i = 0; i < 16; i++)  applyStimulus(0, 0, 0, 1, '0, "drain");

    for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 1, 0, 32'(i), "fill2");
    applyStimulus(0, 0, 1, 0, 32'd99, "pushFull");
    for (int i = 0; i < 16; i++)  applyStimulus(0, 0, 0, 1, '0, "drainOvf");
    applyStimulus(0, 0, 0, 1, '0, "popEmpty");
    applyStimulus(0, 1, 0, 0, '0, "clearFlags");

    for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 1, 0, 32'(i), "fill3");
    applyStimulus(0, 0, 1, 1, 32'd17, "pushPopFull");
    for (int i = 0; i < 16; i++)  applyStimulus(0, 0, 0, 1, '0, "drainSim");
    applyStimulus(0, 1, 0, 0, '0, "clear2");
    applyStimulus(0, 0, 1, 1, 32'd5, "pushPopEmpty");
    applyStimulus(0, 1, 1, 1, 32'd6, "clearWins");

    for (int i = 0; i < 23; i++)
      applyStimulus(1, 0, ($urandom_range(9) < 7), ($urandom_range(9) < 5), $urandom, "wrap5");
    randomRun(1, 120, "rand5");

    applyStimulus(2, 0, 1, 0, 32'hA5, "fwftPush");
    applyStimulus(2, 0, 0, 0, '0, "fwftHold");
    applyStimulus(2, 0, 0, 1, '0, "fwftPop");
    applyStimulus(2, 0, 1, 0, 32'd1, "fwftPush1");
    applyStimulus(2, 0, 1, 0, 32'd2, "fwftPush2");
    applyStimulus(2, 0, 0, 1, '0, "fwftPopTo2");
    randomRun(2, 200, "randFwft");

    applyStimulus(0, 1, 0, 0, '0, "clear3");
    for (int i = 1; i <= 7; i++) applyStimulus(0, 0, 1, 0, 32'(i + 40), "fill7");
    applyStimulus(0, 0, 1, 1, 32'd50, "preReset");
    reset = 1'b0;
    #2 modelReset();
    for (int k = 0; k < 3; k++) checkOutput(k, "asyncReset");
    #1 reset = 1'b1;
    applyStimulus(0, 0, 1, 0, 32'd3, "postResetPush");
    applyStimulus(0, 0, 0, 1, '0, "postResetPop");
    chk("postResetValue", dout[0], 32'd3);

    randomRun(0, 300, "rand16");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fifo_status.md
Name: fifo_status

Overview:
Parametrised synchronous FIFO, the successor to the basic push/pop FIFO used between pipeline stages.
- Adds fill-level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Adds a selectable first-word-fall-through (FWFT) read mode and supports non-power-of-two depth.
- Single clock domain; drop-in for producer/consumer buffering in the datapath.

Parameters:
nrOfEntries, 16, FIFO depth in words; any value >= 2, power of two not required.
bitWidth, 32, data word width in bits.
almostFullLevel, 12, almostFull asserts when fillLevel >= this value; range 1..nrOfEntries.
almostEmptyLevel, 4, almostEmpty asserts when fillLevel <= this value; range 0..nrOfEntries-1.
fwftMode, 0, selects read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
clock  input  1  sole clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush.
push  input  1  write request.
pop  input  1  read request.
pushData  input  bitWidth  write data.
popData  output  bitWidth  read data.
full  output  1  fillLevel == nrOfEntries.
empty  output  1  fillLevel == 0.
almostFull  output  1  threshold flag.
almostEmpty  output  1  threshold flag.
fillLevel  output  $clog2(nrOfEntries+1)  number of stored words.
overflow  output  1  sticky: push was attempted while full.
underflow  output  1  sticky: pop was attempted while empty.

Behaviour:
Reset:
- reset low clears readPtr, writePtr, fillLevel, popData (mode 0), overflow and underflow immediately, without waiting for a clock edge.
- After reset: empty=1, full=0, almostEmpty=1, almostFull=0 (assuming almostFullLevel >= 1).
- Storage array is not reset.
- Reset asserted mid-operation discards all contents; the first pop after release sees an empty FIFO.

Clear:
- Synchronous; highest priority over push and pop in the same cycle.
- Same effect as reset, but at the rising edge.

Push and pop acceptance:
- Push accepted iff push=1 and (full=0, or pop is accepted in the same cycle).
- Accepted push writes pushData at writePtr; writePtr then increments, wrapping from nrOfEntries-1 to 0.
- Push while full without a pop: data dropped, storage unchanged, overflow set to 1.
- Pop accepted iff pop=1 and empty=0; readPtr then increments with the same wrap rule.
- Pop while empty: ignored, underflow set to 1. This applies even when push=1 in the same cycle; the push is still accepted.
- Simultaneous accepted push and pop: fillLevel unchanged. This includes the full case: when full with push=1 and pop=1, both are accepted and the FIFO stays full.
- fillLevel changes by +1 on push only, -1 on pop only, 0 on both or neither.

Status flags:
- full, empty, almostFull and almostEmpty are decoded from registered fillLevel, so they reflect the state after the most recent edge.
- No same-cycle combinational path from push or pop to any status output.

Read modes:
- Mode 0: on an accepted pop, popData loads mem[readPtr] at that edge and is valid from that edge; it holds its value otherwise.
- Mode 1: popData = mem[readPtr] continuously. The head word is visible from the edge after it is pushed into an empty FIFO. pop acknowledges and advances to the next word. popData is undefined while empty=1.

Error flags:
- overflow and underflow remain set until reset or clear.
- Setting either flag never alters FIFO contents or pointers.

Test Plan:
1. Fill and drain (depth 16, mode 0): push 1..16 on consecutive cycles -> almostFull=1 after 12th push, full=1 and fillLevel=16 after 16th; pop 16 times -> popData 1..16 in order, each valid after its pop edge, empty=1 at end, underflow=0, overflow=0.
2. Overflow and underflow:
   - When full, push 99 -> overflow=1, fillLevel stays 16, draining yields 1..16 (99 absent).
   - Pop on empty -> underflow=1.
   - clear -> both flags 0, empty=1.
3. Simultaneous operations:
   - Full, push=1 and pop=1 with pushData=17 -> popData=1, fillLevel=16, full=1, overflow=0; full drain ends with 17.
   - Empty, push=1 and pop=1 with 5 -> fillLevel=1, underflow=1.
4. Wrap-around, non-power-of-two (nrOfEntries=5): run 23 push/pop interleaved cycles -> output sequence matches input exactly, fillLevel never exceeds 5, full asserts only at 5.
5. FWFT (fwftMode=1): push 0xA5 into empty FIFO -> popData=0xA5 from the next cycle with no pop; pop -> empty=1; push 1,2 then pop -> popData shows 2.
6. Async reset mid-operation: with fillLevel=7, drive reset low between edges -> fillLevel=0, empty=1, flags 0 before the next edge; after release, push 3 then pop returns 3.
